// File: rtl/trap_seq_ctrl_pkg.sv
// Shared constants for the commit-point trap controller: CSR addresses,
// exception cause codes, mstatus bit positions and the sequencer states.
package trap_seq_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [3:0] CAUSE_MISAL   = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;

    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MCAUSE  = 3'd2,
        W_MTVAL   = 3'd3,
        W_MSTATUS = 3'd4,
        M_MSTATUS = 3'd5,
        REDIRECT  = 3'd6
    } state_t;

endpackage

// File: rtl/trap_seq_ctrl_cause_enc.sv
// Priority encoder from the WB trap flags to {take, is_int, cause}.
// Interrupts win over every synchronous exception; mret is not a trap here.
module trap_cause_enc
    import trap_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            int_pending,
    input  logic [3:0]      int_code,
    input  logic            misal,
    input  logic            illg,
    input  logic            ecall,
    input  logic            ebreak,
    output logic            take,
    output logic            is_int,
    output logic [XLEN-1:0] cause
);

    // First matching flag in priority order selects the cause.
    always_comb begin
        take   = 1'b1;
        is_int = 1'b0;
        cause  = '0;
        if (int_pending) begin
            is_int = 1'b1;
            cause  = {1'b1, {(XLEN-5){1'b0}}, int_code};
        end else if (misal) begin
            cause = XLEN'(CAUSE_MISAL);
        end else if (illg) begin
            cause = XLEN'(CAUSE_ILLEGAL);
        end else if (ecall) begin
            cause = XLEN'(CAUSE_ECALL);
        end else if (ebreak) begin
            cause = XLEN'(CAUSE_BREAK);
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/trap_seq_ctrl.sv
// Commit-point trap controller. Detects traps/mret at WB, kills and flushes,
// walks the single CSR write port through the update sequence, then issues
// one PC redirect.
module trap_seq_ctrl
    import trap_seq_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [XLEN-1:0]       wb_pc,
    input  logic [XLEN-1:0]       wb_inst,
    input  logic                  wb_inst_addr_misal,
    input  logic                  wb_is_illg_inst,
    input  logic                  wb_is_ecall_inst,
    input  logic                  wb_is_ebreak_inst,
    input  logic                  wb_is_mret,
    input  logic                  int_pending,
    input  logic [3:0]            int_code,
    input  logic [XLEN-1:0]       csr_mstatus,
    input  logic [XLEN-1:0]       csr_mtvec,
    input  logic [XLEN-1:0]       csr_mepc,
    output logic                  wb_kill,
    output logic                  flush,
    output logic                  csr_we,
    output logic [CSR_ADDR_W-1:0] csr_waddr,
    output logic [XLEN-1:0]       csr_wdata,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  trap_busy
);

    state_t          state;
    logic [XLEN-1:0] epc_q, cause_q, tval_q, mstatus_q;
    logic            is_int_q, is_mret_q;

    logic            take, is_int;
    logic [XLEN-1:0] cause;
    logic            detect_ok, trap_go, mret_go;
    logic [XLEN-1:0] trap_ms, mret_ms;

    trap_cause_enc #(.XLEN(XLEN)) u_enc (
        .int_pending (int_pending),
        .int_code    (int_code),
        .misal       (wb_inst_addr_misal),
        .illg        (wb_is_illg_inst),
        .ecall       (wb_is_ecall_inst),
        .ebreak      (wb_is_ebreak_inst),
        .take        (take),
        .is_int      (is_int),
        .cause       (cause)
    );

    // Flags only count at a valid WB boundary while the sequencer is free.
    assign detect_ok = !rst && wb_valid && (state == IDLE);
    assign trap_go   = detect_ok && take;
    assign mret_go   = detect_ok && !take && wb_is_mret;
    assign wb_kill   = trap_go;
    assign flush     = trap_go || mret_go || (state != IDLE);
    assign trap_busy = (state != IDLE);

    // New mstatus images for trap entry and for mret.
    always_comb begin
        trap_ms                       = csr_mstatus;
        trap_ms[MS_MPIE]              = csr_mstatus[MS_MIE];
        trap_ms[MS_MIE]               = 1'b0;
        trap_ms[MS_MPP_HI:MS_MPP_LO]  = 2'b11;
        mret_ms                       = csr_mstatus;
        mret_ms[MS_MIE]               = csr_mstatus[MS_MPIE];
        mret_ms[MS_MPIE]              = 1'b1;
    end

    // Sequencer state and the values captured at the detect cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            epc_q     <= '0;
            cause_q   <= '0;
            tval_q    <= '0;
            mstatus_q <= '0;
            is_int_q  <= 1'b0;
            is_mret_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_go) begin
                        epc_q     <= wb_pc;
                        cause_q   <= cause;
                        tval_q    <= (!is_int && !wb_inst_addr_misal && wb_is_illg_inst) ? wb_inst : '0;
                        mstatus_q <= trap_ms;
                        is_int_q  <= is_int;
                        is_mret_q <= 1'b0;
                        state     <= W_MEPC;
                    end else if (mret_go) begin
                        mstatus_q <= mret_ms;
                        is_int_q  <= 1'b0;
                        is_mret_q <= 1'b1;
                        state     <= M_MSTATUS;
                    end
                end
                W_MEPC:    state <= W_MCAUSE;
                W_MCAUSE:  state <= W_MTVAL;
                W_MTVAL:   state <= W_MSTATUS;
                W_MSTATUS: state <= REDIRECT;
                M_MSTATUS: state <= REDIRECT;
                default:   state <= IDLE;
            endcase
        end
    end

    // Moore CSR-port and redirect outputs decoded from state and captures.
    always_comb begin
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            W_MEPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_ADDR_W'(CSR_MEPC);
                csr_wdata = epc_q;
            end
            W_MCAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_ADDR_W'(CSR_MCAUSE);
                csr_wdata = cause_q;
            end
            W_MTVAL: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_ADDR_W'(CSR_MTVAL);
                csr_wdata = tval_q;
            end
            W_MSTATUS, M_MSTATUS: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_ADDR_W'(CSR_MSTATUS);
                csr_wdata = mstatus_q;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                if (is_mret_q) begin
                    redirect_pc = csr_mepc;
                end else begin
                    redirect_pc = {csr_mtvec[XLEN-1:2], 2'b00};
                    // Vectored mode offsets only interrupts, by 4*cause.
                    if (csr_mtvec[1:0] == 2'b01 && is_int_q)
                        redirect_pc = redirect_pc + XLEN'({cause_q[3:0], 2'b00});
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Directed bench for trap_seq_ctrl: a queue-based model of the expected
// per-cycle outputs checked at every negedge, plus literal spot checks.
module tb_trap_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [31:0] wb_pc, wb_inst;
    logic        misal, illg, ecall, ebreak, mret;
    logic        int_pending;
    logic [3:0]  int_code;
    logic [31:0] mstatus, mtvec, mepc;
    logic        wb_kill, flush, csr_we, redirect_valid, trap_busy;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    trap_seq_ctrl #(.XLEN(32), .CSR_ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .wb_inst_addr_misal(misal), .wb_is_illg_inst(illg), .wb_is_ecall_inst(ecall),
        .wb_is_ebreak_inst(ebreak), .wb_is_mret(mret), .int_pending(int_pending),
        .int_code(int_code), .csr_mstatus(mstatus), .csr_mtvec(mtvec), .csr_mepc(mepc),
        .wb_kill(wb_kill), .flush(flush), .csr_we(csr_we), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_busy(trap_busy)
    );

    // One expected cycle of outputs; rkind 0=no redirect, 1=trap, 2=mret.
    typedef struct {
        bit          kill, flsh, busy, we;
        logic [11:0] addr;
        logic [31:0] data;
        int          rkind;
        bit          intr;
        logic [31:0] cause;
    } exp_t;

    exp_t plan[$];

    function automatic exp_t blank(bit busy);
        exp_t e;
        e.kill = 0; e.flsh = busy; e.busy = busy; e.we = 0; e.addr = 0; e.data = 0;
        e.rkind = 0; e.intr = 0; e.cause = 0;
        return e;
    endfunction

    function automatic exp_t wr(logic [11:0] a, logic [31:0] d);
        exp_t e = blank(1);
        e.we = 1; e.addr = a; e.data = d;
        return e;
    endfunction

    // Build the whole expected sequence from the architectural trap rules.
    task automatic build_plan();
        exp_t e;
        logic [31:0] cause, tval, ms;
        bit intr, exc;
        if (!wb_valid) return;
        intr = int_pending;
        exc  = misal | illg | ecall | ebreak;
        if (intr || exc) begin
            if (intr)        cause = 32'h8000_0000 | 32'(int_code);
            else if (misal)  cause = 0;
            else if (illg)   cause = 2;
            else if (ecall)  cause = 11;
            else             cause = 3;
            tval = (!intr && !misal && illg) ? wb_inst : 32'h0;
            ms = mstatus & ~32'h0000_0088;
            if (mstatus[3]) ms = ms | 32'h80;
            ms = ms | 32'h1800;
            e = blank(0); e.kill = 1; e.flsh = 1; plan.push_back(e);
            plan.push_back(wr(12'h341, wb_pc));
            plan.push_back(wr(12'h342, cause));
            plan.push_back(wr(12'h343, tval));
            plan.push_back(wr(12'h300, ms));
            e = blank(1); e.rkind = 1; e.intr = intr; e.cause = cause; plan.push_back(e);
        end else if (mret) begin
            ms = (mstatus & ~32'h8) | 32'h80;
            if (mstatus[7]) ms = ms | 32'h8;
            e = blank(0); e.flsh = 1; plan.push_back(e);
            plan.push_back(wr(12'h300, ms));
            e = blank(1); e.rkind = 2; plan.push_back(e);
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%08h want 0x%08h", name, $time, got, want);
        end
    endtask

    // Compare process: checks every non-reset cycle against the model.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] rpc;
        if (chk_en) begin
            if (rst) begin
                plan.delete();
            end else begin
                if (plan.size() == 0) build_plan();
                e = (plan.size() != 0) ? plan[0] : blank(0);
                rpc = 0;
                if (e.rkind == 1) begin
                    rpc = {mtvec[31:2], 2'b00};
                    if (mtvec[1:0] == 2'b01 && e.intr) rpc = rpc + 4 * 32'(e.cause[3:0]);
                end else if (e.rkind == 2) begin
                    rpc = mepc;
                end
                chk("m_kill",  32'(wb_kill),        32'(e.kill));
                chk("m_flush", 32'(flush),          32'(e.flsh));
                chk("m_busy",  32'(trap_busy),      32'(e.busy));
                chk("m_we",    32'(csr_we),         32'(e.we));
                chk("m_addr",  32'(csr_waddr),      32'(e.addr));
                chk("m_data",  csr_wdata,           e.data);
                chk("m_rv",    32'(redirect_valid), 32'(e.rkind != 0));
                chk("m_rpc",   redirect_pc,         rpc);
                if (plan.size() != 0) void'(plan.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wb_valid = 0; misal = 0; illg = 0; ecall = 0; ebreak = 0; mret = 0;
        int_pending = 0; int_code = 0; wb_pc = 0; wb_inst = 0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1; idle_in(); mstatus = 0; mtvec = 0; mepc = 0;
        run(3);
        rst = 0; chk_en = 1;
        #2;
        chk("rst_flush", 32'(flush), 0);
        chk("rst_busy",  32'(trap_busy), 0);
        chk("rst_we",    32'(csr_we), 0);
        tick();

        // Illegal instruction trap, direct mode.
        wb_valid = 1; illg = 1; wb_pc = 32'h80; wb_inst = 32'hFFFF_FFFF;
        mtvec = 32'h100; mstatus = 32'h8;
        #2 chk("ill_kill", 32'(wb_kill), 1);
        tick(); idle_in();
        #2 chk("ill_mepc_a", 32'(csr_waddr), 32'h341); chk("ill_mepc", csr_wdata, 32'h80);
        tick(); #2 chk("ill_cause", csr_wdata, 2);
        tick(); #2 chk("ill_tval", csr_wdata, 32'hFFFF_FFFF);
        tick(); #2 chk("ill_ms", csr_wdata, 32'h1880);
        tick(); #2 chk("ill_rpc", redirect_pc, 32'h100); chk("ill_rv", 32'(redirect_valid), 1);
        tick(); #2 chk("ill_idle", 32'(trap_busy), 0);
        run(2);

        // Interrupt beats ecall; vectored mtvec.
        wb_valid = 1; int_pending = 1; int_code = 7; ecall = 1; wb_pc = 32'h44;
        mtvec = 32'h101;
        tick(); idle_in();
        tick(); #2 chk("int_cause", csr_wdata, 32'h8000_0007);
        tick(); #2 chk("int_tval", csr_wdata, 0);
        run(2); #2 chk("int_rpc", redirect_pc, 32'h11C);
        run(2);

        // mret.
        wb_valid = 1; mret = 1; mstatus = 32'h80; mepc = 32'h200;
        #2 chk("mret_kill", 32'(wb_kill), 0); chk("mret_flush", 32'(flush), 1);
        tick(); idle_in();
        #2 chk("mret_ms", csr_wdata, 32'h88);
        tick(); #2 chk("mret_rpc", redirect_pc, 32'h200);
        run(2);

        // Interrupt held while WB is empty, then taken at first valid WB.
        mtvec = 32'h100; mstatus = 32'h8;
        int_pending = 1; int_code = 3;
        for (int i = 0; i < 3; i++) begin
            #2 chk("nowb_busy", 32'(trap_busy), 0);
            tick();
        end
        wb_valid = 1; wb_pc = 32'h300;
        #2 chk("wb_int_kill", 32'(wb_kill), 1);
        tick(); idle_in();
        run(6);

        // Reset at T+2 aborts the sequence; next ecall runs fully.
        wb_valid = 1; ecall = 1; wb_pc = 32'h400;
        tick(); idle_in();
        tick(); rst = 1;
        tick(); rst = 0;
        #2 chk("abort_we", 32'(csr_we), 0); chk("abort_busy", 32'(trap_busy), 0);
        chk("abort_flush", 32'(flush), 0); chk("abort_rv", 32'(redirect_valid), 0);
        run(6);
        wb_valid = 1; ecall = 1; wb_pc = 32'h500;
        tick(); idle_in();
        tick(); #2 chk("ec_cause", csr_wdata, 11);
        run(3); #2 chk("ec_rpc", redirect_pc, 32'h100);
        run(2);

        // Ecall while busy is ignored; ecall right after REDIRECT is taken.
        wb_valid = 1; ecall = 1; wb_pc = 32'h600;
        tick(); wb_pc = 32'h604;
        run(4); #2 chk("b2b_rv", 32'(redirect_valid), 1);
        tick(); #2 chk("b2b_kill", 32'(wb_kill), 1);
        tick(); idle_in();
        #2 chk("b2b_epc", csr_wdata, 32'h604);
        run(7);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/trap_seq_ctrl.md
Name: trap_seq_ctrl

Overview:
- Commit-point trap controller for the 5-stage core.
- Watches the write-back stage for exceptions, interrupts and mret, and kills the trapping instruction's register write.
- Flushes younger pipeline stages, then sequences the single CSR write port through the trap-entry or mret CSR updates.
- Issues one PC redirect to IF when the sequence completes.

Parameters:
XLEN, 32, datapath width
CSR_ADDR_W, 12, CSR address width

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
wb_valid  in  1  WB stage holds a valid instruction this cycle
wb_pc  in  XLEN  PC of the WB instruction
wb_inst  in  XLEN  encoding of the WB instruction
wb_inst_addr_misal  in  1  instruction-address-misaligned flag
wb_is_illg_inst  in  1  illegal-instruction flag
wb_is_ecall_inst  in  1  ecall flag
wb_is_ebreak_inst  in  1  ebreak flag
wb_is_mret  in  1  mret flag
int_pending  in  1  interrupt pending, already masked by mie/mstatus.MIE
int_code  in  4  interrupt cause code
csr_mstatus  in  XLEN  current mstatus
csr_mtvec  in  XLEN  current mtvec
csr_mepc  in  XLEN  current mepc
wb_kill  out  1  suppress the WB register-file write this cycle (combinational)
flush  out  1  invalidate IF/ID/EX/MEM stage registers
csr_we  out  1  CSR write strobe
csr_waddr  out  CSR_ADDR_W  CSR write address
csr_wdata  out  XLEN  CSR write data
redirect_valid  out  1  one-cycle PC redirect strobe
redirect_pc  out  XLEN  redirect target
trap_busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (synchronous, rst=1): state=IDLE; captured epc/cause/tval/mstatus registers=0; all outputs 0.
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, M_MSTATUS, REDIRECT.
- Trap detect, evaluated only in IDLE with wb_valid=1. Priority, highest first:
  - int_pending: cause={1'b1, 27'b0, int_code}
  - misal: cause=0
  - illegal: cause=2
  - ecall: cause=11
  - ebreak: cause=3
  - mret: no cause; handled as the return path below
- Trap entry, detect cycle T:
  - wb_kill=1 and flush=1, combinational.
  - Capture epc=wb_pc; capture tval=wb_inst for illegal, else 0.
  - Capture mstatus with MPIE=MIE, MIE=0, MPP=2'b11, computed from csr_mstatus at T.
  - Next state W_MEPC.
- CSR write sequence, one write per cycle, Moore outputs from state and captured registers:
  - T+1: csr_we=1, 0x341 (mepc) <= epc
  - T+2: 0x342 (mcause) <= cause
  - T+3: 0x343 (mtval) <= tval
  - T+4: 0x300 (mstatus) <= captured mstatus
- T+5, REDIRECT:
  - redirect_valid=1.
  - redirect_pc = {mtvec[XLEN-1:2], 2'b00}, plus 4*cause[3:0] when mtvec[1:0]==1 and the trap is an interrupt.
- T+6: IDLE. Trap latency from detect to redirect is 5 cycles.
- mret, detect cycle T:
  - flush=1, wb_kill=0.
  - Capture mstatus with MIE=MPIE, MPIE=1.
  - Next state M_MSTATUS.
  - T+1: write mstatus. T+2: REDIRECT with redirect_pc=csr_mepc sampled at T+2.
- flush stays 1 in every non-IDLE state. wb_kill is 1 only in the trap detect cycle.
- Inputs are ignored outside IDLE: wb_valid and all flags are don't-care, and int_pending is not latched.
- Simultaneous flags: int_pending beats everything, including mret. An exception flag together with mret takes the exception.
- wb_valid=0: no detect, even if int_pending=1. Interrupts are taken only at a valid WB boundary.
- csr_waddr and csr_wdata are 0 whenever csr_we=0.
- Reset mid-sequence: immediate return to IDLE. Partial CSR updates are not rolled back; no redirect is issued.
- Back-to-back: an exception in the cycle right after REDIRECT (state IDLE) is detected normally.

Decomposition:
- Shared defines:
  - CSR addresses MSTATUS/MTVEC/MEPC/MCAUSE/MTVAL
  - cause codes
  - mstatus bit indices MIE=3, MPIE=7, MPP=12:11
  - state encoding
- One combinational sub-module, trap_cause_enc: priority encoder from flags to {take, is_int, cause}.

Test Plan:
- Illegal at wb_pc=0x80, wb_inst=0xFFFFFFFF, mtvec=0x100, mstatus=0x8 -> wb_kill at T; writes 0x341=0x80, 0x342=2, 0x343=0xFFFFFFFF, 0x300=0x1880; redirect 0x100 at T+5.
- int_pending, int_code=7, mtvec=0x101, ecall also set -> cause 0x80000007; redirect 0x11C; ecall ignored.
- mret, mstatus=0x80, mepc=0x200 -> no kill; mstatus write 0x88 at T+1; redirect 0x200 at T+2.
- int_pending with wb_valid=0 for 3 cycles -> no action; detect on the first wb_valid=1.
- rst pulsed at T+2 of a trap -> all outputs 0 next cycle; no redirect; the next ecall runs the full sequence.
- Ecall presented while busy, then again right after REDIRECT -> first ignored; second detected in the first IDLE cycle.
